// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and constants for the BCD game timer.
//   state_e        - controller states (IDLE, RUN, DONE, EXPIRED)
//   BCD_W          - width of the packed hh:mm:ss BCD word
//   S0..H1         - digit positions inside the BCD word (nibble index)
//   MOD_*          - per-digit modulus for the carry/borrow chain
//   preset_valid() - checks that a BCD word is a legal hh:mm:ss value
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, EXPIRED} state_e;

  localparam int unsigned BCD_W      = 24;
  localparam int unsigned NUM_DIGITS = 6;

  localparam int unsigned S0 = 0;
  localparam int unsigned S1 = 1;
  localparam int unsigned M0 = 2;
  localparam int unsigned M1 = 3;
  localparam int unsigned H0 = 4;
  localparam int unsigned H1 = 5;

  localparam int unsigned MOD_S0 = 10;
  localparam int unsigned MOD_S1 = 6;
  localparam int unsigned MOD_M0 = 10;
  localparam int unsigned MOD_M1 = 6;
  localparam int unsigned MOD_H0 = 10;
  localparam int unsigned MOD_H1 = 10;

  function automatic logic preset_valid(input logic [BCD_W-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (p[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (p[S1*4 +: 4] > 4'd5 || p[M1*4 +: 4] > 4'd5) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one modulo-MOD BCD digit of the timer chain.
//   clk, rst      - clock, synchronous active-low reset (digit -> 0)
//   load/load_val - parallel load, highest priority
//   inc / dec     - step up / down with wrap (inc wins if both set)
//   digit         - current digit value
//   carry_out     - digit sits at MOD-1, so an increment here carries
//   borrow_out    - digit sits at 0, so a decrement here borrows
// carry_out/borrow_out are position flags rather than gated strobes; the
// top ANDs them along the chain, which also yields saturation and
// last-second detection without a separate comparator.
module bcd_digit #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam logic [3:0] TOP = 4'(MOD - 1);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (inc) begin
      digit_d = (digit_q == TOP) ? '0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? TOP : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) digit_q <= '0;
    else      digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign carry_out  = (digit_q == TOP);
  assign borrow_out = (digit_q == '0);

endmodule

// File: rtl/game_timer.sv
// game_timer: BCD hh:mm:ss stopwatch / countdown with pause, expiry and
// best-time capture.
//   clk, rst   - clock, synchronous active-low reset
//   start      - pulse: latch mode/preset and start counting
//   clear      - pulse: back to IDLE showing 00:00:00, best kept
//   run_en     - level: counting allowed (0 = paused)
//   finish     - pulse: freeze in DONE and record best (count-up only)
//   mode       - 0 = count up, 1 = count down (sampled on start)
//   preset     - countdown start value, BCD {h1,h0,m1,m0,s1,s0}
//   bcd        - current time, BCD
//   sec_tick   - one-cycle pulse per BCD update
//   running    - state is RUN
//   expired    - countdown hit zero or count-up saturated
//   best       - lowest finished count-up time, BCD
//   best_valid - best holds a recorded time
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned PRE_W  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             run_en,
  input  logic             finish,
  input  logic             mode,
  input  logic [BCD_W-1:0] preset,
  output logic [BCD_W-1:0] bcd,
  output logic             sec_tick,
  output logic             running,
  output logic             expired,
  output logic [BCD_W-1:0] best,
  output logic             best_valid
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             sec_tick_q, sec_tick_d;
  logic [BCD_W-1:0] best_q, best_d;
  logic             best_valid_q, best_valid_d;

  logic             load;
  logic [BCD_W-1:0] load_val;
  logic             tick_inc, tick_dec;
  logic [5:0]       inc_v, dec_v, carry_v, borrow_v;
  logic             start_ok, saturated, last_sec;

  // Increment/decrement ripple: a digit steps only when every lower digit
  // is at its wrap point.
  always_comb begin
    inc_v[S0] = tick_inc;
    inc_v[S1] = inc_v[S0] & carry_v[S0];
    inc_v[M0] = inc_v[S1] & carry_v[S1];
    inc_v[M1] = inc_v[M0] & carry_v[M0];
    inc_v[H0] = inc_v[M1] & carry_v[M1];
    inc_v[H1] = inc_v[H0] & carry_v[H0];
    dec_v[S0] = tick_dec;
    dec_v[S1] = dec_v[S0] & borrow_v[S0];
    dec_v[M0] = dec_v[S1] & borrow_v[S1];
    dec_v[M1] = dec_v[M0] & borrow_v[M0];
    dec_v[H0] = dec_v[M1] & borrow_v[M1];
    dec_v[H1] = dec_v[H0] & borrow_v[H0];
  end

  // All digits at their maximum means 99:59:59.
  assign saturated = &carry_v;
  // 00:00:01: the next decrement lands on zero.
  assign last_sec  = (&borrow_v[H1:S1]) && (bcd[S0*4 +: 4] == 4'd1);
  assign start_ok  = start && (!mode || preset_valid(preset));

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    mode_d       = mode_q;
    sec_tick_d   = 1'b0;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    load         = 1'b0;
    load_val     = '0;
    tick_inc     = 1'b0;
    tick_dec     = 1'b0;

    if (clear) begin
      state_d = IDLE;
      load    = 1'b1;
      pre_d   = '0;
    end else if (start_ok) begin
      mode_d   = mode;
      load     = 1'b1;
      load_val = mode ? preset : '0;
      pre_d    = '0;
      state_d  = (mode && preset == '0) ? EXPIRED : RUN;
    end else if (finish && state_q == RUN) begin
      state_d = DONE;
      if (!mode_q && (!best_valid_q || bcd < best_q)) begin
        best_d       = bcd;
        best_valid_d = 1'b1;
      end
    end else if (state_q == RUN && run_en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (!mode_q) begin
          if (saturated) begin
            state_d = EXPIRED;
          end else begin
            tick_inc   = 1'b1;
            sec_tick_d = 1'b1;
          end
        end else begin
          tick_dec   = 1'b1;
          sec_tick_d = 1'b1;
          if (last_sec) state_d = EXPIRED;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      mode_q       <= 1'b0;
      sec_tick_q   <= 1'b0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      mode_q       <= mode_d;
      sec_tick_q   <= sec_tick_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  bcd_digit #(.MOD(MOD_S0)) u_s0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[S0*4 +: 4]),
    .inc(inc_v[S0]), .dec(dec_v[S0]), .digit(bcd[S0*4 +: 4]),
    .carry_out(carry_v[S0]), .borrow_out(borrow_v[S0])
  );
  bcd_digit #(.MOD(MOD_S1)) u_s1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[S1*4 +: 4]),
    .inc(inc_v[S1]), .dec(dec_v[S1]), .digit(bcd[S1*4 +: 4]),
    .carry_out(carry_v[S1]), .borrow_out(borrow_v[S1])
  );
  bcd_digit #(.MOD(MOD_M0)) u_m0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[M0*4 +: 4]),
    .inc(inc_v[M0]), .dec(dec_v[M0]), .digit(bcd[M0*4 +: 4]),
    .carry_out(carry_v[M0]), .borrow_out(borrow_v[M0])
  );
  bcd_digit #(.MOD(MOD_M1)) u_m1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[M1*4 +: 4]),
    .inc(inc_v[M1]), .dec(dec_v[M1]), .digit(bcd[M1*4 +: 4]),
    .carry_out(carry_v[M1]), .borrow_out(borrow_v[M1])
  );
  bcd_digit #(.MOD(MOD_H0)) u_h0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[H0*4 +: 4]),
    .inc(inc_v[H0]), .dec(dec_v[H0]), .digit(bcd[H0*4 +: 4]),
    .carry_out(carry_v[H0]), .borrow_out(borrow_v[H0])
  );
  bcd_digit #(.MOD(MOD_H1)) u_h1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[H1*4 +: 4]),
    .inc(inc_v[H1]), .dec(dec_v[H1]), .digit(bcd[H1*4 +: 4]),
    .carry_out(carry_v[H1]), .borrow_out(borrow_v[H1])
  );

  assign sec_tick   = sec_tick_q;
  assign running    = (state_q == RUN);
  assign expired    = (state_q == EXPIRED);
  assign best       = best_q;
  assign best_valid = best_valid_q;

endmodule
